// File: rtl/lsu_seq.sv
// lsu_seq: sequential load/store unit running a vrb command/response handshake.
// Ports: execute request (i_req_*, o_req_ready), retire (o_done_*), vrb cmd/rsp.
module lsu_seq #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_load,
    input  logic [1:0]    i_req_size,
    input  logic          i_req_unsigned,
    input  logic [AW-1:0] i_req_base,
    input  logic [AW-1:0] i_req_offset,
    input  logic [DW-1:0] i_req_wdata,
    output logic          o_done_valid,
    output logic [DW-1:0] o_done_rdata,
    output logic          o_done_err,
    output logic          o_done_misalign,
    output logic [AW-1:0] o_done_addr,
    output logic          o_vrb_cmd_valid,
    input  logic          i_vrb_cmd_ready,
    output logic [AW-1:0] o_vrb_cmd_addr,
    output logic          o_vrb_cmd_read,
    output logic [DW-1:0] o_vrb_cmd_wdata,
    output logic [DW/8-1:0] o_vrb_cmd_wmask,
    input  logic          i_vrb_rsp_valid,
    output logic          o_vrb_rsp_ready,
    input  logic          i_vrb_rsp_err,
    input  logic [DW-1:0] i_vrb_rsp_rdata
);

    localparam int NB = DW / 8;
    localparam int OB = $clog2(NB);

    typedef enum logic [1:0] {IDLE, CMD, RSP, DONE} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q;
    logic [1:0]    size_q;
    logic          load_q, uns_q;
    logic [OB-1:0] lane_q;
    logic [DW-1:0] wdata_q;
    logic [NB-1:0] wmask_q;
    logic [15:0]   cnt_q;

    logic [AW-1:0] ea;
    logic [OB-1:0] lane_n;
    logic [2:0]    am;
    logic          misal, accept, tmo_hit;
    logic [DW-1:0] st_wdata, shifted, keep, ext;
    logic [NB-1:0] st_wmask;
    logic          sgn;

    function automatic logic [DW-1:0] keep_of(input logic [1:0] s);
        logic [DW-1:0] k;
        case (s)
            2'd0:    k = DW'(8'hFF);
            2'd1:    k = DW'(16'hFFFF);
            2'd2:    k = DW'(32'hFFFF_FFFF);
            default: k = '1;
        endcase
        return k;
    endfunction

    function automatic logic [NB-1:0] mask_of(input logic [1:0] s);
        logic [7:0] m;
        case (s)
            2'd0:    m = 8'h01;
            2'd1:    m = 8'h03;
            2'd2:    m = 8'h0F;
            default: m = 8'hFF;
        endcase
        return m[NB-1:0];
    endfunction

    // Request-side datapath: effective address, alignment, store lane placement.
    always_comb begin
        ea     = i_req_base + i_req_offset;
        lane_n = ea[OB-1:0];
        case (i_req_size)
            2'd0:    am = 3'd0;
            2'd1:    am = 3'd1;
            2'd2:    am = 3'd3;
            default: am = 3'd7;
        endcase
        misal    = (32'(i_req_size) > OB) || ((ea[OB-1:0] & am[OB-1:0]) != '0);
        st_wdata = (i_req_wdata & keep_of(i_req_size)) << {lane_n, 3'b000};
        st_wmask = mask_of(i_req_size) << lane_n;
    end

    // Response-side datapath: align to lane 0, truncate, then extend.
    always_comb begin
        shifted = i_vrb_rsp_rdata >> {lane_q, 3'b000};
        keep    = keep_of(size_q);
        case (size_q)
            2'd0:    sgn = shifted[7];
            2'd1:    sgn = shifted[15];
            2'd2:    sgn = shifted[31];
            default: sgn = shifted[DW-1];
        endcase
        ext = (shifted & keep) | ((sgn && !uns_q) ? ~keep : '0);
    end

    // Count reaching TIMEOUT on this cycle's increment ends the wait.
    assign tmo_hit = (TIMEOUT != 0) && ((cnt_q + 16'd1) == 16'(TIMEOUT));

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d         = state_q;
        o_req_ready     = 1'b0;
        o_vrb_rsp_ready = 1'b0;
        accept          = 1'b0;
        case (state_q)
            IDLE: begin
                o_req_ready     = 1'b1;
                o_vrb_rsp_ready = 1'b1;
                accept          = i_req_valid;
                if (i_req_valid) state_d = misal ? DONE : CMD;
            end
            CMD: if (i_vrb_cmd_ready) state_d = RSP;
            RSP: begin
                o_vrb_rsp_ready = 1'b1;
                if (i_vrb_rsp_valid || tmo_hit) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            addr_q          <= '0;
            size_q          <= '0;
            load_q          <= 1'b0;
            uns_q           <= 1'b0;
            lane_q          <= '0;
            wdata_q         <= '0;
            wmask_q         <= '0;
            cnt_q           <= '0;
            o_vrb_cmd_valid <= 1'b0;
            o_done_valid    <= 1'b0;
            o_done_err      <= 1'b0;
            o_done_misalign <= 1'b0;
            o_done_rdata    <= '0;
            o_done_addr     <= '0;
        end else begin
            o_vrb_cmd_valid <= (state_d == CMD);
            o_done_valid    <= (state_d == DONE);
            if (accept) begin
                addr_q  <= ea;
                size_q  <= i_req_size;
                load_q  <= i_req_load;
                uns_q   <= i_req_unsigned;
                lane_q  <= lane_n;
                wdata_q <= i_req_load ? '0 : st_wdata;
                wmask_q <= i_req_load ? '0 : st_wmask;
                if (misal) begin
                    o_done_err      <= 1'b0;
                    o_done_misalign <= 1'b1;
                    o_done_rdata    <= '0;
                    o_done_addr     <= ea;
                end
            end
            if (state_q == CMD && i_vrb_cmd_ready) cnt_q <= '0;
            if (state_q == RSP) begin
                if (i_vrb_rsp_valid) begin
                    o_done_err      <= i_vrb_rsp_err;
                    o_done_misalign <= 1'b0;
                    o_done_rdata    <= load_q ? ext : '0;
                    o_done_addr     <= addr_q;
                end else begin
                    cnt_q <= cnt_q + 16'd1;
                    if (tmo_hit) begin
                        o_done_err      <= 1'b1;
                        o_done_misalign <= 1'b0;
                        o_done_rdata    <= '0;
                        o_done_addr     <= addr_q;
                    end
                end
            end
        end
    end

    assign o_vrb_cmd_addr  = addr_q;
    assign o_vrb_cmd_read  = load_q;
    assign o_vrb_cmd_wdata = wdata_q;
    assign o_vrb_cmd_wmask = wmask_q;

endmodule

// File: tb/tb_lsu_seq.sv
// tb_lsu_seq: directed bench for lsu_seq, a DW=32/TIMEOUT=4 instance and a
// DW=64 instance sharing clock and reset.
module tb_lsu_seq;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // DW=32 instance
    logic        a_req_valid = 0, a_req_ready, a_req_load = 0, a_req_unsigned = 0;
    logic [1:0]  a_req_size = 0;
    logic [31:0] a_req_base = 0, a_req_offset = 0, a_req_wdata = 0;
    logic        a_done_valid, a_done_err, a_done_misalign;
    logic [31:0] a_done_rdata, a_done_addr;
    logic        a_cmd_valid, a_cmd_ready = 0, a_cmd_read;
    logic [31:0] a_cmd_addr, a_cmd_wdata;
    logic [3:0]  a_cmd_wmask;
    logic        a_rsp_valid = 0, a_rsp_ready, a_rsp_err = 0;
    logic [31:0] a_rsp_rdata = 0;

    // DW=64 instance
    logic        b_req_valid = 0, b_req_ready, b_req_load = 0, b_req_unsigned = 0;
    logic [1:0]  b_req_size = 0;
    logic [31:0] b_req_base = 0, b_req_offset = 0;
    logic [63:0] b_req_wdata = 0;
    logic        b_done_valid, b_done_err, b_done_misalign;
    logic [63:0] b_done_rdata;
    logic [31:0] b_done_addr;
    logic        b_cmd_valid, b_cmd_ready = 0, b_cmd_read;
    logic [31:0] b_cmd_addr;
    logic [63:0] b_cmd_wdata;
    logic [7:0]  b_cmd_wmask;
    logic        b_rsp_valid = 0, b_rsp_ready, b_rsp_err = 0;
    logic [63:0] b_rsp_rdata = 0;

    lsu_seq #(.AW(32), .DW(32), .TIMEOUT(4)) u_a (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(a_req_valid), .o_req_ready(a_req_ready),
        .i_req_load(a_req_load), .i_req_size(a_req_size),
        .i_req_unsigned(a_req_unsigned), .i_req_base(a_req_base),
        .i_req_offset(a_req_offset), .i_req_wdata(a_req_wdata),
        .o_done_valid(a_done_valid), .o_done_rdata(a_done_rdata),
        .o_done_err(a_done_err), .o_done_misalign(a_done_misalign),
        .o_done_addr(a_done_addr),
        .o_vrb_cmd_valid(a_cmd_valid), .i_vrb_cmd_ready(a_cmd_ready),
        .o_vrb_cmd_addr(a_cmd_addr), .o_vrb_cmd_read(a_cmd_read),
        .o_vrb_cmd_wdata(a_cmd_wdata), .o_vrb_cmd_wmask(a_cmd_wmask),
        .i_vrb_rsp_valid(a_rsp_valid), .o_vrb_rsp_ready(a_rsp_ready),
        .i_vrb_rsp_err(a_rsp_err), .i_vrb_rsp_rdata(a_rsp_rdata)
    );

    lsu_seq #(.AW(32), .DW(64), .TIMEOUT(255)) u_b (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(b_req_valid), .o_req_ready(b_req_ready),
        .i_req_load(b_req_load), .i_req_size(b_req_size),
        .i_req_unsigned(b_req_unsigned), .i_req_base(b_req_base),
        .i_req_offset(b_req_offset), .i_req_wdata(b_req_wdata),
        .o_done_valid(b_done_valid), .o_done_rdata(b_done_rdata),
        .o_done_err(b_done_err), .o_done_misalign(b_done_misalign),
        .o_done_addr(b_done_addr),
        .o_vrb_cmd_valid(b_cmd_valid), .i_vrb_cmd_ready(b_cmd_ready),
        .o_vrb_cmd_addr(b_cmd_addr), .o_vrb_cmd_read(b_cmd_read),
        .o_vrb_cmd_wdata(b_cmd_wdata), .o_vrb_cmd_wmask(b_cmd_wmask),
        .i_vrb_rsp_valid(b_rsp_valid), .o_vrb_rsp_ready(b_rsp_ready),
        .i_vrb_rsp_err(b_rsp_err), .i_vrb_rsp_rdata(b_rsp_rdata)
    );

    // Results of the last acc32 access
    int          r_dcyc;
    logic        r_cv, r_stable, r_cread, r_derr, r_dmis;
    logic [31:0] r_caddr, r_cwdata, r_drdata, r_daddr;
    logic [3:0]  r_cwmask;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Runs one access on the DW=32 instance starting at cycle 0 (just after
    // a rising edge). cdly = cmd_ready-low cycles, rdly = response delay.
    task automatic acc32(input logic ld, input logic [1:0] sz, input logic un,
                         input logic [31:0] base, input logic [31:0] off,
                         input logic [31:0] wd, input logic [31:0] rd,
                         input logic rerr, input int cdly, input int rdly);
        int   ncmd = 0;
        int   nrsp = 0;
        logic inrsp = 1'b0;
        r_dcyc = -1; r_cv = 1'b0; r_stable = 1'b1;
        a_req_valid = 1'b1; a_req_load = ld; a_req_size = sz;
        a_req_unsigned = un; a_req_base = base; a_req_offset = off;
        a_req_wdata = wd;
        @(posedge clk); #1;
        a_req_valid = 1'b0;
        for (int c = 1; c <= 30; c++) begin
            a_cmd_ready = a_cmd_valid && (ncmd >= cdly);
            a_rsp_valid = inrsp && (nrsp == rdly);
            a_rsp_rdata = rd;
            a_rsp_err   = rerr;
            @(negedge clk);
            if (a_cmd_valid) begin
                if (!r_cv) begin
                    r_caddr = a_cmd_addr; r_cread = a_cmd_read;
                    r_cwdata = a_cmd_wdata; r_cwmask = a_cmd_wmask;
                end else if (r_caddr !== a_cmd_addr || r_cread !== a_cmd_read ||
                             r_cwdata !== a_cmd_wdata || r_cwmask !== a_cmd_wmask)
                    r_stable = 1'b0;
                r_cv = 1'b1;
            end
            if (a_done_valid) begin
                r_dcyc = c; r_drdata = a_done_rdata; r_derr = a_done_err;
                r_dmis = a_done_misalign; r_daddr = a_done_addr;
            end
            if (a_rsp_valid) inrsp = 1'b0;
            else if (inrsp) nrsp++;
            if (a_cmd_valid && a_cmd_ready) begin inrsp = 1'b1; nrsp = 0; end
            if (a_cmd_valid) ncmd++;
            @(posedge clk); #1;
            if (r_dcyc >= 0) break;
        end
        a_cmd_ready = 1'b0;
        a_rsp_valid = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", a_req_ready, 1);
        chk("rst_cmd_valid", a_cmd_valid, 0);
        chk("rst_done_valid", a_done_valid, 0);
        chk("rst_done_err", a_done_err, 0);
        chk("rst_done_mis", a_done_misalign, 0);
        chk("rst_done_rdata", a_done_rdata, 0);
        chk("rst_done_addr", a_done_addr, 0);
        chk("rst_rsp_ready", a_rsp_ready, 1);
        @(posedge clk); #1;

        acc32(1, 2, 0, 32'h100, 32'h4, 0, 32'hDEADBEEF, 0, 0, 0);
        chk("lw_cmd_addr", r_caddr, 32'h104);
        chk("lw_cmd_read", r_cread, 1);
        chk("lw_cmd_wmask", r_cwmask, 0);
        chk("lw_done_cyc", 64'(r_dcyc), 3);
        chk("lw_rdata", r_drdata, 32'hDEADBEEF);
        chk("lw_err", r_derr, 0);
        chk("lw_addr", r_daddr, 32'h104);
        @(negedge clk);
        chk("lw_done_pulse", a_done_valid, 0);
        chk("lw_idle_ready", a_req_ready, 1);
        @(posedge clk); #1;

        acc32(0, 0, 0, 32'h100, 32'h3, 32'h000000A5, 32'hDEADBEEF, 0, 0, 0);
        chk("sb_wmask", r_cwmask, 4'b1000);
        chk("sb_wdata", r_cwdata, 32'hA5000000);
        chk("sb_read", r_cread, 0);
        chk("sb_rdata", r_drdata, 0);
        chk("sb_done_cyc", 64'(r_dcyc), 3);

        acc32(0, 1, 0, 32'h100, 32'h0, 32'h1234BEEF, 0, 0, 0, 0);
        chk("sh_wmask", r_cwmask, 4'b0011);
        chk("sh_wdata", r_cwdata, 32'h0000BEEF);

        acc32(1, 0, 0, 32'h100, 32'h3, 0, 32'h80000000, 0, 0, 0);
        chk("lb_rdata", r_drdata, 32'hFFFFFF80);
        acc32(1, 0, 1, 32'h100, 32'h3, 0, 32'h80000000, 0, 0, 0);
        chk("lbu_rdata", r_drdata, 32'h00000080);
        acc32(1, 1, 0, 32'h100, 32'h2, 0, 32'h7FFF1234, 0, 0, 0);
        chk("lh_pos_rdata", r_drdata, 32'h00007FFF);

        acc32(0, 1, 0, 32'h100, 32'h1, 32'h55, 0, 0, 0, 0);
        chk("sh_mis_nocmd", r_cv, 0);
        chk("sh_mis_cyc", 64'(r_dcyc), 1);
        chk("sh_mis_flag", r_dmis, 1);
        chk("sh_mis_addr", r_daddr, 32'h101);
        acc32(1, 3, 0, 32'h100, 32'h0, 0, 0, 0, 0, 0);
        chk("ld32_mis_flag", r_dmis, 1);
        chk("ld32_mis_nocmd", r_cv, 0);

        acc32(1, 2, 0, 32'h200, 32'hFFFFFFFC, 0, 32'h12345678, 1, 0, 0);
        chk("neg_off_addr", r_caddr, 32'h1FC);
        chk("buserr_err", r_derr, 1);
        chk("buserr_mis", r_dmis, 0);

        acc32(1, 2, 0, 32'h100, 32'h8, 0, 32'h0BADF00D, 0, 5, 0);
        chk("stall_stable", r_stable, 1);
        chk("stall_done_cyc", 64'(r_dcyc), 8);
        chk("stall_rdata", r_drdata, 32'h0BADF00D);

        acc32(1, 2, 0, 32'h100, 32'hC, 0, 32'h99999999, 0, 0, 255);
        chk("tmo_done_cyc", 64'(r_dcyc), 6);
        chk("tmo_err", r_derr, 1);
        chk("tmo_rdata", r_drdata, 0);
        a_rsp_valid = 1'b1; a_rsp_err = 1'b1; a_rsp_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        chk("stale_rsp_ready", a_rsp_ready, 1);
        chk("stale_no_done", a_done_valid, 0);
        @(posedge clk); #1;
        a_rsp_valid = 1'b0;
        @(negedge clk);
        chk("stale_no_done2", a_done_valid, 0);
        chk("stale_req_ready", a_req_ready, 1);
        @(posedge clk); #1;
        acc32(1, 2, 0, 32'h100, 32'h10, 0, 32'h11223344, 0, 0, 0);
        chk("post_tmo_cyc", 64'(r_dcyc), 3);
        chk("post_tmo_rdata", r_drdata, 32'h11223344);
        chk("post_tmo_err", r_derr, 0);

        // DW=64: SW into upper lanes
        b_req_valid = 1'b1; b_req_load = 1'b0; b_req_size = 2'd2;
        b_req_base = 32'h100; b_req_offset = 32'h4; b_req_wdata = 64'h1_CAFEF00D;
        @(posedge clk); #1;
        b_req_valid = 1'b0; b_cmd_ready = 1'b1;
        @(negedge clk);
        chk("b_sw_wmask", b_cmd_wmask, 8'hF0);
        chk("b_sw_wdata", b_cmd_wdata, 64'hCAFEF00D_00000000);
        @(posedge clk); #1;
        b_cmd_ready = 1'b0; b_rsp_valid = 1'b1;
        @(posedge clk); #1;
        b_rsp_valid = 1'b0;
        @(negedge clk);
        chk("b_sw_done", b_done_valid, 1);
        @(posedge clk); #1;

        // DW=64: LH at lane 6
        b_req_valid = 1'b1; b_req_load = 1'b1; b_req_size = 2'd1;
        b_req_base = 32'h100; b_req_offset = 32'h6;
        @(posedge clk); #1;
        b_req_valid = 1'b0; b_cmd_ready = 1'b1;
        @(negedge clk);
        chk("b_lh_cmd_valid", b_cmd_valid, 1);
        chk("b_lh_cmd_addr", b_cmd_addr, 32'h106);
        @(posedge clk); #1;
        b_cmd_ready = 1'b0; b_rsp_valid = 1'b1;
        b_rsp_rdata = 64'h8001_0000_0000_0000;
        @(posedge clk); #1;
        b_rsp_valid = 1'b0;
        @(negedge clk);
        chk("b_lh_done", b_done_valid, 1);
        chk("b_lh_rdata", b_done_rdata, 64'hFFFF_FFFF_FFFF_8001);
        @(posedge clk); #1;

        // DW=64: reset while in CMD
        b_req_valid = 1'b1; b_req_load = 1'b1; b_req_size = 2'd2;
        b_req_base = 32'h200; b_req_offset = 32'h0;
        @(posedge clk); #1;
        b_req_valid = 1'b0;
        @(negedge clk);
        chk("b_pre_rst_cmd", b_cmd_valid, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("b_rst_cmd_valid", b_cmd_valid, 0);
        chk("b_rst_req_ready", b_req_ready, 1);
        chk("b_rst_done_valid", b_done_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        b_rsp_valid = 1'b1; b_rsp_rdata = 64'h1234;
        @(posedge clk); #1;
        b_rsp_valid = 1'b0;
        @(negedge clk);
        chk("b_stale_no_done", b_done_valid, 0);
        chk("b_stale_req_ready", b_req_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_seq.md
# lsu_seq

Parametrised sequential load/store unit that sits between the execute stage and the vrb bus. Unlike the single-cycle combinational LSU path, it runs a real vrb handshake: it registers the command, holds it until accepted, waits for the response, and flags misaligned accesses, bus errors and response timeouts. The execute stage stalls on `o_req_ready` and retires on `o_done_valid`. One access is outstanding at a time.

## Interface
Parameters:
- `AW`, 32, address width.
- `DW`, 32, data width; legal values are 32 or 64. `NB = DW/8` lanes, `OB = log2(NB)`.
- `TIMEOUT`, 255, maximum number of RSP-state cycles without a response; 0 disables the timeout. Counter width is 16 bits.

Ports (name, direction, width, meaning):
- `clk` in 1: the single clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `i_req_valid` in 1: execute presents an access.
- `o_req_ready` out 1: high only in IDLE.
- `i_req_load` in 1: 1 = load, 0 = store.
- `i_req_size` in 2: 0 = byte, 1 = half, 2 = word, 3 = dword.
- `i_req_unsigned` in 1: zero-extend the load result.
- `i_req_base` in AW: rs1 value.
- `i_req_offset` in AW: sign-extended immediate.
- `i_req_wdata` in DW: rs2 value, right-aligned.
- `o_done_valid` out 1: one-cycle retire pulse.
- `o_done_rdata` out DW: extended load data; 0 for stores.
- `o_done_err` out 1: bus error or timeout.
- `o_done_misalign` out 1: misaligned address or unsupported size.
- `o_done_addr` out AW: effective address, for mtval.
- `o_vrb_cmd_valid`, `i_vrb_cmd_ready`, `o_vrb_cmd_addr`[AW], `o_vrb_cmd_read`, `o_vrb_cmd_wdata`[DW], `o_vrb_cmd_wmask`[NB]: command channel.
- `i_vrb_rsp_valid`, `o_vrb_rsp_ready`, `i_vrb_rsp_err`, `i_vrb_rsp_rdata`[DW]: response channel.

## Operation
- States: IDLE, CMD, RSP, DONE.
- Accept: the request is accepted when `i_req_valid & o_req_ready`. On acceptance the unit registers:
  - `addr = base + offset`, modulo 2^AW.
  - size, load, unsigned, `lane = addr[OB-1:0]`.
- Misalign check: the access is misaligned when `addr mod (1<<size) != 0`, or when `size > OB`.
  - Misaligned goes IDLE -> DONE with `o_done_misalign = 1`. No bus command is issued.
- Aligned access: IDLE -> CMD.
- CMD state:
  - `o_vrb_cmd_valid = 1`.
  - `o_vrb_cmd_addr` carries the full byte address, not lane-aligned.
  - Command fields stay stable until `i_vrb_cmd_ready`; then CMD -> RSP.
- Store encoding:
  - `wmask = ((1<<(1<<size))-1) << lane`.
  - `wdata = i_req_wdata << (8*lane)`.
  - Bytes outside the mask are 0.
- Load encoding: `wmask = 0`, `wdata = 0`.
- RSP state:
  - `o_vrb_rsp_ready = 1`.
  - On `i_vrb_rsp_valid`: capture `rdata >> (8*lane)`, truncate to the access size, then sign-extend (or zero-extend if unsigned) to DW. `o_done_err = i_vrb_rsp_err`. Go to DONE.
  - A store response also completes the access; its rdata is ignored.
- Timeout: the counter clears on entry to RSP and increments every RSP cycle with no response. When `TIMEOUT != 0` and the count reaches TIMEOUT: go to DONE with `o_done_err = 1` and `o_done_rdata = 0`.
- DONE: `o_done_valid = 1` for exactly one cycle, then IDLE.
- Stale responses: `o_vrb_rsp_ready` is also 1 in IDLE. Responses arriving in IDLE (late, after a timeout) are consumed and discarded without effect.
- Reset:
  - State returns to IDLE.
  - `o_req_ready` = 1 (it is decoded from IDLE).
  - `o_vrb_cmd_valid`, `o_done_valid`, `o_done_err` and `o_done_misalign` = 0.
  - `o_done_rdata` and `o_done_addr` = 0.
  - Timeout counter = 0.
- Reset mid-access drops `o_vrb_cmd_valid` at the reset edge. A pending response is later discarded as stale.

## Timing
- All outputs are registered except `o_req_ready` and `o_vrb_rsp_ready`, which are decoded from the state.
- Best-case bus access, with request accepted at cycle 0:
  - `cmd_valid` at cycle 1.
  - With `cmd_ready` at cycle 1, RSP at cycle 2.
  - With `rsp_valid` at cycle 2, `o_done_valid` at cycle 3.
- Misaligned access: `o_done_valid` at cycle 1.
- Next request: the earliest acceptance is the cycle after DONE, giving a throughput of one access per 4 cycles.
- Each cycle of `cmd_ready` low adds one cycle of latency; each cycle of rsp delay adds one cycle.
- `o_done_*` fields are valid only while `o_done_valid` is high. They are held at their last value otherwise.

## Test plan
- DW=32, LW at base 0x100, offset 4; `cmd_ready` and `rsp_valid` immediate; rdata 0xDEADBEEF -> `cmd_addr` 0x104, `cmd_read` 1, done at cycle 3 with rdata 0xDEADBEEF and err 0.
- SB at address 0x103 with wdata 0x000000A5 -> wmask 4'b1000, wdata 0xA5000000. LB at 0x103 with rdata 0x80000000 -> 0xFFFFFF80. LBU -> 0x00000080.
- SH at 0x101 -> no `cmd_valid`; done at cycle 1 with misalign 1 and `o_done_addr` 0x101. DW=32 with size 3 -> misalign 1.
- Hold `cmd_ready` low for 5 cycles -> `cmd_valid` and all command fields stable throughout; done at cycle 8.
- TIMEOUT=4 and `rsp_valid` never asserted -> done with err 1 after 4 RSP cycles. A late rsp is then discarded, and the next LW completes normally.
- DW=64, LH at 0x106 with rdata 0x8001_0000_0000_0000 -> 0xFFFF_FFFF_FFFF_8001. Assert `rst_n` = 0 during CMD -> `cmd_valid` is 0 at the next edge and `o_req_ready` is 1.
